// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [PC_W-1:0] TRAP_VECTOR_DEF = 32'h0000_0100;
    localparam logic [PC_W-1:0] PC_STEP_DEF     = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        TRAP = 2'd3
    } fetch_state_e;

    // Word-align a byte address
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] x);
        return {x[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch FSM: drives nextPC, runs the imem req/ack handshake, hands
// instructions to decode and raises a trap on fetch bus errors.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] TRAP_VECTOR = TRAP_VECTOR_DEF,
    parameter logic [PC_W-1:0] PC_STEP     = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] next_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    input  logic            imem_err,
    output logic            out_valid,
    output logic [PC_W-1:0] out_instr,
    output logic [PC_W-1:0] out_pc,
    input  logic            out_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            trap_valid,
    output logic [PC_W-1:0] trap_pc
);

    fetch_state_e    state;
    logic            kill_q;
    logic            trap_q;
    logic [PC_W-1:0] target_q;
    logic [PC_W-1:0] target;

    assign target    = align_pc(redirect_pc);
    assign imem_addr = pc;

    // A redirect landing in the trap cycle cancels the trap report
    assign trap_valid = trap_q & ~redirect_valid;

    // Next-PC and request decode from state
    always_comb begin
        next_pc  = pc;
        imem_req = 1'b0;
        if (reset) begin
            case (state)
                IDLE, HOLD, TRAP: begin
                    if (redirect_valid) next_pc = target;
                end
                REQ: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        if (redirect_valid)  next_pc = target;
                        else if (kill_q)     next_pc = target_q;
                        else if (imem_err)   next_pc = TRAP_VECTOR;
                        else                 next_pc = pc + PC_STEP;
                    end
                end
                default: next_pc = pc;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            kill_q    <= 1'b0;
            target_q  <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            trap_q    <= 1'b0;
            trap_pc   <= '0;
        end else begin
            trap_q <= 1'b0;
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        kill_q <= 1'b0;
                        // Killed or redirected responses are dropped; PC already retargeted
                        if (!redirect_valid && !kill_q) begin
                            if (imem_err) begin
                                trap_pc <= pc;
                                trap_q  <= 1'b1;
                                state   <= TRAP;
                            end else begin
                                out_instr <= imem_rdata;
                                out_pc    <= pc;
                                out_valid <= 1'b1;
                                state     <= HOLD;
                            end
                        end
                    end else if (redirect_valid) begin
                        kill_q   <= 1'b1;
                        target_q <= target;
                    end
                end
                HOLD: begin
                    if (redirect_valid || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= REQ;
                    end
                end
                TRAP: state <= REQ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a transaction-level fetch model.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, next_pc, imem_addr, imem_rdata, out_instr, out_pc, redirect_pc, trap_pc;
    logic        imem_req, imem_ack, imem_err, out_valid, out_ready, redirect_valid, trap_valid;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // ProgramCounter stand-in, reset from the same active-low line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else        pc <= next_pc;
    end

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .pc(pc), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_err(imem_err),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .trap_valid(trap_valid), .trap_pc(trap_pc)
    );

    always @(posedge clk) begin
        if (reset && imem_ack)
            assert (imem_req) else $error("FAIL ack_protocol: ack with imem_req=0");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model state
    bit          m_start, m_fetch, m_hold, m_trap, m_killed;
    logic [31:0] m_addr, m_cur, m_ktgt, m_hinstr, m_hpc, m_taddr;
    bit          busy, prev_r;
    int          cnt;
    bit          force_redirect;
    logic [31:0] force_target;

    task automatic model_reset();
        m_start = 1'b1; m_fetch = 1'b0; m_hold = 1'b0; m_trap = 1'b0; m_killed = 1'b0;
        m_addr = '0; m_cur = '0; busy = 1'b0; prev_r = 1'b0; cnt = 0;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            1:       return 32'($urandom);
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    // One cycle: called at a falling edge, returns at the next falling edge
    task automatic step();
        bit          r, ack, new_req;
        logic [31:0] tgt;
        r = force_redirect || (!prev_r && ($urandom_range(0, 9) == 0));
        redirect_valid = r;
        redirect_pc    = force_redirect ? force_target : pick_target();
        force_redirect = 1'b0;
        tgt       = redirect_pc & 32'hFFFF_FFFC;
        out_ready = ($urandom_range(0, 2) != 0);
        new_req = 1'b0;
        if (imem_req && !busy) begin
            busy = 1'b1; cnt = $urandom_range(0, 3); new_req = 1'b1;
        end
        ack        = busy && imem_req && (cnt == 0);
        imem_ack   = ack;
        imem_err   = ack && ($urandom_range(0, 7) == 0);
        imem_rdata = 32'($urandom);
        #1;
        check("imem_req", 32'(imem_req), 32'(m_fetch));
        check("out_valid", 32'(out_valid), 32'(m_hold));
        if (m_hold) begin
            check("out_instr", out_instr, m_hinstr);
            check("out_pc", out_pc, m_hpc);
        end
        check("trap_valid", 32'(trap_valid), 32'(m_trap && !r));
        if (m_trap && !r) check("trap_pc", trap_pc, m_taddr);
        if (new_req) begin
            check("fetch_addr", imem_addr, m_addr);
            m_cur = m_addr;
        end else if (m_fetch) begin
            check("addr_stable", imem_addr, m_cur);
        end
        if (m_fetch && !ack) check("pc_frozen", next_pc, pc);

        if (m_start) begin
            if (r) m_addr = tgt;
            m_start = 1'b0; m_fetch = 1'b1;
        end else if (m_fetch) begin
            if (ack) begin
                busy = 1'b0;
                if (r) begin
                    m_addr = tgt; m_killed = 1'b0;
                end else if (m_killed) begin
                    m_addr = m_ktgt; m_killed = 1'b0;
                end else if (imem_err) begin
                    m_trap = 1'b1; m_taddr = m_cur; m_addr = 32'h0000_0100; m_fetch = 1'b0;
                end else begin
                    m_hold = 1'b1; m_hinstr = imem_rdata; m_hpc = m_cur;
                    m_addr = m_cur + 32'd4; m_fetch = 1'b0;
                end
            end else begin
                if (r) begin m_killed = 1'b1; m_ktgt = tgt; end
                if (busy) cnt--;
            end
        end else if (m_hold) begin
            if (r) m_addr = tgt;
            if (r || out_ready) begin m_hold = 1'b0; m_fetch = 1'b1; end
        end else if (m_trap) begin
            if (r) m_addr = tgt;
            m_trap = 1'b0; m_fetch = 1'b1;
        end
        prev_r = r;
        @(negedge clk);
    endtask

    task automatic reset_mid_req();
        int guard = 0;
        while (!m_fetch && guard < 50) begin step(); guard++; end
        check("pre_reset_req", 32'(imem_req), 32'd1);
        reset = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0; imem_err = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_trap_valid", 32'(trap_valid), 32'd0);
        check("rst_next_pc", next_pc, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("rst_late_ack", 32'(out_valid), 32'd0);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = '0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        force_redirect = 1'b0; force_target = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_req", 32'(imem_req), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_trap_valid", 32'(trap_valid), 32'd0);
        check("reset_out_instr", out_instr, 32'd0);
        check("reset_trap_pc", trap_pc, 32'd0);
        check("reset_next_pc", next_pc, pc);
        reset = 1'b1;
        model_reset();

        repeat (1200) step();
        // Drive the PC to the top of the address space to exercise wrap
        while (!m_hold) step();
        force_redirect = 1'b1; force_target = 32'hFFFF_FFFE;
        repeat (300) step();
        reset_mid_req();
        repeat (1200) step();
        reset_mid_req();
        repeat (300) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
